fsx_capture: RTL and testbench
==============================

Name: fsx_capture

Overview:
- Video capture receiver: the receiving end of the FSX raster interface.
- Consumes the hs/vs sync pair plus 8-bit RGB332 pixels at pixel rate.
- Recovers the active window from sync edges and porch counts, then writes each active pixel into a linear 8-bit frame buffer (VRAM-style write port).
- Used for loopback verification of the GPU output and for capturing external 240p sources into memory.

Parameters:
- H_RES, 320, active pixels per line
- V_RES, 240, active lines per frame
- H_BP, 46, pixel clocks from the first hs-inactive cycle to the first active pixel
- V_BP, 14, line-start events from vs end to the first active line
- H_POL, 0, hs polarity (0: active-low, 1: active-high)
- V_POL, 0, vs polarity (0: active-low, 1: active-high)
- ADDR_W, 17, frame buffer address width (must satisfy H_RES*V_RES <= 2^ADDR_W)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- nreset  in  1  asynchronous active-low reset
- vga_hs  in  1  horizontal sync, polarity set by H_POL
- vga_vs  in  1  vertical sync, polarity set by V_POL
- vga_r  in  3  red
- vga_g  in  3  green
- vga_b  in  2  blue
- capture_en  in  1  level; enables capture of frames that start while it is high
- vram_addr  out  ADDR_W  write address, y*H_RES+x
- vram_d  out  8  write data {r,g,b}
- vram_we  out  1  write strobe, one cycle per pixel
- busy  out  1  high while in CAPTURE
- frame_done  out  1  one-cycle pulse after the last pixel write of a frame
- sync_error  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: asserting nreset immediately (asynchronously) forces all outputs to 0, all counters to 0, and the FSM to WAIT_VS. No state survives a reset mid-frame.
- Input stage: hs, vs and rgb are registered once on vga_clk.
  - Normalised sync: hs_a = H_POL ? hs : ~hs, and likewise vs_a.
  - All timing decisions use the registered copies.
- Line start event: the falling edge of hs_a, i.e. the first registered cycle with hs_a=0 after a cycle with hs_a=1.
- hpos: 10-bit counter.
  - Set to 0 on the line start cycle; +1 every cycle after that.
  - Saturates at 1023.
- Frame start event: the falling edge of vs_a.
- lcnt: 9-bit counter.
  - Set to all-ones on frame start.
  - +1 on each line start event, so the first line start after vs end gives lcnt=0.
  - Saturates.
- Active pixel: hpos in [H_BP, H_BP+H_RES-1] and lcnt in [V_BP, V_BP+V_RES-1].
- FSM:
  - WAIT_VS: idle, no writes. On a frame start event with capture_en=1, clear the address counter to 0 and go to CAPTURE. If capture_en=0, stay in WAIT_VS.
  - CAPTURE: busy=1. Each active pixel produces one registered write:
    - vram_we=1, vram_d=registered rgb, vram_addr=counter; then counter+1.
    - Pixel on the pins at cycle t appears on the write port at t+2.
    - In the cycle after the write at address H_RES*V_RES-1: pulse frame_done, go to DONE.
  - DONE: one cycle, then WAIT_VS. The next frame start needs a fresh vs assertion and release.
- capture_en falling during CAPTURE: the current frame completes; no further frames are captured.
- Abort conditions in CAPTURE (pulse sync_error, vram_we=0 from that cycle, go to WAIT_VS):
  - vs_a asserted before the last pixel is written.
  - A line start event while lcnt is in the active range and hpos < H_BP+H_RES (short line).
- Simultaneous events:
  - A frame start in WAIT_VS in the same cycle as a line start: the frame start takes effect and lcnt=all-ones.
  - Abort has priority over the final write.
- vram_addr holds its last value when vram_we=0. vram_d is don't-care when vram_we=0.
- Counters never wrap into the active range.

Test Plan:
- Source matches the FSX 240p defaults (422 clocks/line, 262 lines, sync-on-low), pixel = (x+y)&0xFF, capture_en=1 -> exactly 76800 writes per frame, addr 0..76799 in order, data correct, one frame_done per frame, busy low between frames.
- capture_en=0 for a whole frame -> zero vram_we pulses, no frame_done, no sync_error.
- capture_en dropped at line 120 -> that frame still completes all 76800 writes with frame_done; the following frame produces no writes.
- vs asserted early at active line 100 -> single sync_error pulse, writes stop at addr 100*320+k, the next frame restarts from addr 0 and completes.
- hs line-start forced at hpos=200 on active line 50 -> sync_error pulse, no frame_done; the next clean frame captures correctly.
- nreset pulsed mid-capture -> all outputs 0 during reset; the partial frame after release is ignored; the first complete frame after a vs cycle captures from addr 0. Repeat with H_POL=1, V_POL=1 and inverted source syncs -> identical captured data.

Source files
------------

// File: rtl/fsx_capture.sv
// FSX raster capture receiver: recovers the active window from hs/vs timing
// and streams every active RGB332 pixel into a linear frame-buffer write port.
module fsx_capture #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int H_BP   = 46,
    parameter int V_BP   = 14,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0,
    parameter int ADDR_W = 17
) (
    input  logic              vga_clk,
    input  logic              nreset,
    input  logic              vga_hs,
    input  logic              vga_vs,
    input  logic [2:0]        vga_r,
    input  logic [2:0]        vga_g,
    input  logic [1:0]        vga_b,
    input  logic              capture_en,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_d,
    output logic              vram_we,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_error
);

    localparam logic [9:0]      H_FIRST   = 10'(H_BP);
    localparam logic [9:0]      H_END     = 10'(H_BP + H_RES);
    localparam logic [8:0]      V_FIRST   = 9'(V_BP);
    localparam logic [8:0]      V_END     = 9'(V_BP + V_RES);
    localparam logic [ADDR_W:0] TOTAL     = (ADDR_W + 1)'(H_RES * V_RES);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [9:0]      HPOS_MAX  = 10'h3FF;
    localparam logic [8:0]      LCNT_ALL1 = 9'h1FF;
    // All-ones is the post-frame-start value, so saturation stops one below it.
    localparam logic [8:0]      LCNT_SAT  = 9'h1FE;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    logic              hs_a_r, vs_a_r, hs_a_d_r, vs_a_d_r;
    logic [7:0]        rgb_r;
    logic [9:0]        hpos_r, hpos_s;
    logic [8:0]        lcnt_r, lcnt_s;
    logic              line_start_s, frame_start_s;
    logic              pix_active_s, short_line_s;
    state_t            state_r, state_nxt_s;
    logic [ADDR_W:0]   cnt_r, cnt_nxt_s;
    logic [ADDR_W-1:0] vram_addr_r, addr_nxt_s;
    logic [7:0]        vram_d_r, d_nxt_s;
    logic              vram_we_r, we_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              frame_done_r, done_nxt_s;
    logic              sync_error_r, err_nxt_s;

    // Input register stage; sync is normalised to active-high so reset reads as "not in sync".
    always_ff @(posedge vga_clk or negedge nreset) begin
        if (!nreset) begin
            hs_a_r   <= 1'b0;
            vs_a_r   <= 1'b0;
            hs_a_d_r <= 1'b0;
            vs_a_d_r <= 1'b0;
            rgb_r    <= 8'd0;
        end else begin
            hs_a_r   <= H_POL ? vga_hs : ~vga_hs;
            vs_a_r   <= V_POL ? vga_vs : ~vga_vs;
            hs_a_d_r <= hs_a_r;
            vs_a_d_r <= vs_a_r;
            rgb_r    <= {vga_r, vga_g, vga_b};
        end
    end

    assign line_start_s  = hs_a_d_r & ~hs_a_r;
    assign frame_start_s = vs_a_d_r & ~vs_a_r;

    // Current-cycle raster position; frame start outranks a coincident line start.
    always_comb begin
        hpos_s = hpos_r;
        lcnt_s = lcnt_r;
        if (line_start_s) begin
            hpos_s = 10'd0;
        end else begin
            hpos_s = hpos_r;
        end
        if (frame_start_s) begin
            lcnt_s = LCNT_ALL1;
        end else if (line_start_s && (lcnt_r != LCNT_SAT)) begin
            lcnt_s = lcnt_r + 9'd1;
        end else begin
            lcnt_s = lcnt_r;
        end
    end

    // Raster position registers; hpos_r holds the value the next cycle will see.
    always_ff @(posedge vga_clk or negedge nreset) begin
        if (!nreset) begin
            hpos_r <= 10'd0;
            lcnt_r <= 9'd0;
        end else begin
            hpos_r <= (hpos_s == HPOS_MAX) ? HPOS_MAX : (hpos_s + 10'd1);
            lcnt_r <= lcnt_s;
        end
    end

    assign pix_active_s = (lcnt_s >= V_FIRST) && (lcnt_s < V_END) &&
                          (hpos_s >= H_FIRST) && (hpos_s < H_END);
    // hpos_r at a line start equals the length of the line just ended.
    assign short_line_s = line_start_s && (lcnt_r >= V_FIRST) && (lcnt_r < V_END) &&
                          (hpos_r < H_END);

    // Capture sequencing and next values of the registered write port.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        we_nxt_s    = 1'b0;
        addr_nxt_s  = vram_addr_r;
        d_nxt_s     = vram_d_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_WAIT_VS: begin
                if (frame_start_s && capture_en) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_WAIT_VS;
                end
            end
            ST_CAPTURE: begin
                if (cnt_r == TOTAL) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (vs_a_r || short_line_s) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_WAIT_VS;
                end else if (pix_active_s) begin
                    we_nxt_s   = 1'b1;
                    addr_nxt_s = cnt_r[ADDR_W-1:0];
                    d_nxt_s    = rgb_r;
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_WAIT_VS;
            end
            default: begin
                state_nxt_s = ST_WAIT_VS;
            end
        endcase
    end

    assign busy_nxt_s = (state_nxt_s == ST_CAPTURE);

    // State and output registers.
    always_ff @(posedge vga_clk or negedge nreset) begin
        if (!nreset) begin
            state_r      <= ST_WAIT_VS;
            cnt_r        <= '0;
            vram_addr_r  <= '0;
            vram_d_r     <= 8'd0;
            vram_we_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            sync_error_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            vram_addr_r  <= addr_nxt_s;
            vram_d_r     <= d_nxt_s;
            vram_we_r    <= we_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= done_nxt_s;
            sync_error_r <= err_nxt_s;
        end
    end

    assign vram_addr  = vram_addr_r;
    assign vram_d     = vram_d_r;
    assign vram_we    = vram_we_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign sync_error = sync_error_r;

endmodule

// File: tb/tb_fsx_capture.sv
// Bench for fsx_capture: a reduced raster source drives two instances (low and
// high sync polarity); a write scoreboard plus per-frame tables check both.
module tb_fsx_capture;

    localparam int H_RES  = 16;
    localparam int V_RES  = 6;
    localparam int H_BP   = 5;
    localparam int V_BP   = 3;
    localparam int ADDR_W = 7;
    localparam int HSW    = 3;
    localparam int LL     = 28;
    localparam int VSL    = 2;
    localparam int NLINES = 13;
    localparam int TOTAL  = H_RES * V_RES;

    logic              vga_clk = 1'b0;
    logic              nreset;
    logic              hs0, vs0, hs1, vs1;
    logic [7:0]        rgb;
    logic              capture_en;
    logic [ADDR_W-1:0] addr_w [2];
    logic [7:0]        d_w    [2];
    logic              we_w   [2];
    logic              busy_w [2];
    logic              done_w [2];
    logic              err_w  [2];

    always #5 vga_clk = ~vga_clk;

    fsx_capture #(.H_RES(H_RES), .V_RES(V_RES), .H_BP(H_BP), .V_BP(V_BP),
                  .H_POL(1'b0), .V_POL(1'b0), .ADDR_W(ADDR_W)) u_dut_lo (
        .vga_clk(vga_clk), .nreset(nreset), .vga_hs(hs0), .vga_vs(vs0),
        .vga_r(rgb[7:5]), .vga_g(rgb[4:2]), .vga_b(rgb[1:0]), .capture_en(capture_en),
        .vram_addr(addr_w[0]), .vram_d(d_w[0]), .vram_we(we_w[0]), .busy(busy_w[0]),
        .frame_done(done_w[0]), .sync_error(err_w[0]));

    fsx_capture #(.H_RES(H_RES), .V_RES(V_RES), .H_BP(H_BP), .V_BP(V_BP),
                  .H_POL(1'b1), .V_POL(1'b1), .ADDR_W(ADDR_W)) u_dut_hi (
        .vga_clk(vga_clk), .nreset(nreset), .vga_hs(hs1), .vga_vs(vs1),
        .vga_r(rgb[7:5]), .vga_g(rgb[4:2]), .vga_b(rgb[1:0]), .capture_en(capture_en),
        .vram_addr(addr_w[1]), .vram_d(d_w[1]), .vram_we(we_w[1]), .busy(busy_w[1]),
        .frame_done(done_w[1]), .sync_error(err_w[1]));

    typedef struct { int addr; int data; int due; } wr_t;
    typedef struct {
        bit en; bit pat;
        int drop_li; int ev_li; int inj_li; int inj_pos; int rst_li; int rst_pos;
        int exp_we; int exp_done; int exp_err;
    } row_t;

    wr_t  wq[$];
    int   dq[$];
    int   eq[$];
    row_t tbl[10];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   model_cap = 1'b0;
    bit   busy_exp = 1'b0;
    int   busy_on_due = -1;
    bit   prev_vs = 1'b0;
    int   cnt_we[2], cnt_done[2], cnt_err[2];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        bit ew, ed, ee;
        ew = (wq.size() > 0) && (wq[0].due == cyc);
        ed = (dq.size() > 0) && (dq[0] == cyc);
        ee = (eq.size() > 0) && (eq[0] == cyc);
        if (busy_on_due == cyc) busy_exp = 1'b1;
        if (ed || ee) busy_exp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("vram_we", i, 32'(we_w[i]), 32'(ew));
            if (ew) begin
                chk("vram_addr", i, 32'(addr_w[i]), wq[0].addr);
                chk("vram_d", i, 32'(d_w[i]), wq[0].data);
            end
            chk("frame_done", i, 32'(done_w[i]), 32'(ed));
            chk("sync_error", i, 32'(err_w[i]), 32'(ee));
            chk("busy", i, 32'(busy_w[i]), 32'(busy_exp));
            cnt_we[i]   += int'(we_w[i]);
            cnt_done[i] += int'(done_w[i]);
            cnt_err[i]  += int'(err_w[i]);
        end
        if (ew) void'(wq.pop_front());
        if (ed) void'(dq.pop_front());
        if (ee) void'(eq.pop_front());
    endtask

    // One pixel clock: check what the DUTs show now, drive the next source cycle, update the model.
    task automatic do_cycle(input bit hs_act, input bit vs_act, input logic [7:0] pix,
                            input bit pix_v, input int paddr, input bit inj, input bit rst_n_v);
        @(negedge vga_clk);
        check_outputs();
        nreset = rst_n_v;
        hs0 = !hs_act; vs0 = !vs_act;
        hs1 = hs_act;  vs1 = vs_act;
        rgb = pix;
        if (!rst_n_v) begin
            wq.delete(); dq.delete(); eq.delete();
            model_cap = 1'b0; busy_exp = 1'b0; busy_on_due = -1;
        end else begin
            if ((vs_act || inj) && model_cap) begin
                eq.push_back(cyc + 2);
                model_cap = 1'b0;
            end
            if (prev_vs && !vs_act && capture_en) begin
                model_cap = 1'b1;
                busy_on_due = cyc + 2;
            end
            if (model_cap && pix_v) begin
                wq.push_back('{paddr, int'(pix), cyc + 2});
                if (paddr == TOTAL - 1) begin
                    dq.push_back(cyc + 3);
                    model_cap = 1'b0;
                end
            end
        end
        prev_vs = vs_act;
        cyc++;
    endtask

    task automatic run_row(input int r);
        row_t t;
        bit   vs_hold, hs_act, vs_act, inj, pv;
        int   rst_cnt, x, y;
        logic [7:0] pix;
        t = tbl[r];
        capture_en = t.en;
        vs_hold = 1'b0;
        rst_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            cnt_we[i] = 0; cnt_done[i] = 0; cnt_err[i] = 0;
        end
        for (int li = 0; li < NLINES; li++) begin
            for (int pos = 0; pos < LL; pos++) begin
                if (li == t.drop_li && pos == 0) capture_en = 1'b0;
                if (li == t.ev_li && pos == 0) vs_hold = 1'b1;
                if (li == t.rst_li && pos == t.rst_pos) rst_cnt = 3;
                vs_act = (li < VSL) || vs_hold;
                hs_act = (pos < HSW) || (li == t.inj_li && pos == t.inj_pos);
                inj    = (li == t.inj_li) && (pos == t.inj_pos + 1);
                x = pos - HSW - H_BP;
                y = li - VSL - V_BP;
                pv = (x >= 0) && (x < H_RES) && (y >= 0) && (y < V_RES);
                pix = t.pat ? 8'(x + y) : 8'($urandom);
                do_cycle(hs_act, vs_act, pix, pv, y * H_RES + x, inj, rst_cnt == 0);
                if (rst_cnt > 0) rst_cnt--;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("row%0d_writes", r), i, cnt_we[i], t.exp_we);
            chk($sformatf("row%0d_frame_done", r), i, cnt_done[i], t.exp_done);
            chk($sformatf("row%0d_sync_error", r), i, cnt_err[i], t.exp_err);
        end
    endtask

    initial begin
        nreset = 1'b0; capture_en = 1'b0;
        hs0 = 1'b1; vs0 = 1'b1; hs1 = 1'b0; vs1 = 1'b0; rgb = 8'd0;
        //           en pat drop ev  inj pos rst pos  we  done err
        tbl[0] = '{1'b1, 1'b1, -1, -1, -1, -1, -1, -1, 96, 1, 0};
        tbl[1] = '{1'b1, 1'b0, -1, -1, -1, -1, -1, -1, 96, 1, 0};
        tbl[2] = '{1'b0, 1'b0, -1, -1, -1, -1, -1, -1,  0, 0, 0};
        tbl[3] = '{1'b1, 1'b0,  8, -1, -1, -1, -1, -1, 96, 1, 0};
        tbl[4] = '{1'b0, 1'b0, -1, -1, -1, -1, -1, -1,  0, 0, 0};
        tbl[5] = '{1'b1, 1'b0, -1,  8, -1, -1, -1, -1, 48, 0, 1};
        tbl[6] = '{1'b1, 1'b0, -1, -1, -1, -1, -1, -1, 96, 1, 0};
        tbl[7] = '{1'b1, 1'b0, -1, -1,  7, 13, -1, -1, 38, 0, 1};
        tbl[8] = '{1'b1, 1'b0, -1, -1, -1, -1,  7, 16, 39, 0, 0};
        tbl[9] = '{1'b1, 1'b1, -1, -1, -1, -1, -1, -1, 96, 1, 0};
        for (int k = 0; k < 4; k++) do_cycle(1'b0, 1'b0, 8'd0, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) do_cycle(1'b0, 1'b0, 8'd0, 1'b0, 0, 1'b0, 1'b1);
        for (int r = 0; r < 10; r++) run_row(r);
        for (int k = 0; k < 10; k++) do_cycle(1'b0, 1'b0, 8'd0, 1'b0, 0, 1'b0, 1'b1);
        chk("pending_writes", 0, wq.size(), 0);
        chk("pending_done", 0, dq.size(), 0);
        chk("pending_err", 0, eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
